// File: rtl/serial_mag_comparator.sv
//------------------------------------------------------------------------------
// serial_mag_comparator
// Purpose : cascadable unsigned magnitude comparator. Compares a and b DIGIT
//           bits per clock, MSB digit first, and stops at the first digit
//           that differs. Yields a three-way result (eq/gt/lt).
// Latency : done is high K cycles after the start edge. K is the 1-based
//           position of the first differing digit, N if all digits match,
//           and 1 if the upper cascade already decided.
// Backpressure: start is only sampled while idle. A start seen while busy is
//           dropped, and the latched operands are left untouched.
// Ports   : clk, rst_n (async active-low), start, a, b, eq_in, gt_in (cascade
//           from the more-significant stage) -> busy, done (1-cycle pulse),
//           eq, gt, lt (held until the next accepted start).
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module serial_mag_comparator #(
    parameter int WIDTH = 16,   // operand width, multiple of DIGIT
    parameter int DIGIT = 2     // bits compared per cycle, >= 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             eq_in,
    input  logic             gt_in,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int N    = WIDTH / DIGIT;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // Operands are held left-aligned and shifted toward the MSB, so the
    // digit under test is always the top DIGIT bits.
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic              eq_in_q;
    logic              gt_in_q;
    logic [IDXW-1:0]   idx;

    logic [DIGIT-1:0]  a_dig;
    logic [DIGIT-1:0]  b_dig;

    logic              accept;
    logic              finish;
    logic              advance;
    logic              res_eq;
    logic              res_gt;
    logic              res_lt;

    assign a_dig = a_sh[WIDTH-1 -: DIGIT];
    assign b_dig = b_sh[WIDTH-1 -: DIGIT];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-edge decision
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        advance   = 1'b0;
        res_eq    = 1'b0;
        res_gt    = 1'b0;
        res_lt    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = COMPARE;
                end
            end
            COMPARE: begin
                // An upper stage that already differs decides on the first
                // compare edge. The local operands are then irrelevant.
                if (!eq_in_q) begin
                    finish = 1'b1;
                    res_gt = gt_in_q;
                    res_lt = ~gt_in_q;
                end else if (a_dig > b_dig) begin
                    finish = 1'b1;
                    res_gt = 1'b1;
                end else if (a_dig < b_dig) begin
                    finish = 1'b1;
                    res_lt = 1'b1;
                end else if (idx == '0) begin
                    finish = 1'b1;
                    res_eq = 1'b1;
                end else begin
                    advance = 1'b1;
                end
                if (finish) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            eq_in_q <= 1'b0;
            gt_in_q <= 1'b0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                a_sh    <= a;
                b_sh    <= b;
                eq_in_q <= eq_in;
                gt_in_q <= gt_in;
                idx     <= IDXW'(N - 1);
                busy    <= 1'b1;
                eq      <= 1'b0;
                gt      <= 1'b0;
                lt      <= 1'b0;
            end else if (finish) begin
                busy <= 1'b0;
                eq   <= res_eq;
                gt   <= res_gt;
                lt   <= res_lt;
            end else if (advance) begin
                a_sh <= a_sh << DIGIT;
                b_sh <= b_sh << DIGIT;
                idx  <= idx - IDXW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_mag_comparator.sv
`timescale 1ns/1ps
module tb_serial_mag_comparator;

    logic        clk;
    logic        rst_n;

    logic        start16, eq16, gt16;
    logic [15:0] a16, b16;
    logic        busy16, done16, oeq16, ogt16, olt16;

    logic        start4, eq4, gt4;
    logic [3:0]  a4, b4;
    logic        busy4, done4, oeq4, ogt4, olt4;

    int vectors;
    int miscompares;

    serial_mag_comparator #(.WIDTH(16), .DIGIT(2)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
        .eq_in(eq16), .gt_in(gt16), .busy(busy16), .done(done16),
        .eq(oeq16), .gt(ogt16), .lt(olt16)
    );

    serial_mag_comparator #(.WIDTH(4), .DIGIT(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .eq_in(eq4), .gt_in(gt4), .busy(busy4), .done(done4),
        .eq(oeq4), .gt(ogt4), .lt(olt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {busy, done, eq, gt, lt} of the selected instance
    function automatic logic [4:0] outs(input bit sel4);
        if (sel4) return {busy4, done4, oeq4, ogt4, olt4};
        return {busy16, done16, oeq16, ogt16, olt16};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: cascade decides if upper bits differ; otherwise an integer
    // compare. Latency is the first digit position (from the MSB) at which
    // the operand prefixes disagree.
    function automatic void model(input int w, input int d, input int av, input int bv,
                                  input bit ei, input bit gi,
                                  output logic [2:0] onehot, output int k);
        bit found;
        if (!ei) begin
            onehot = gi ? 3'b010 : 3'b001;
            k = 1;
        end else begin
            if (av > bv)      onehot = 3'b010;
            else if (av < bv) onehot = 3'b001;
            else              onehot = 3'b100;
            k = w / d;
            found = 0;
            for (int j = 1; j <= w / d; j++) begin
                if (!found && ((av >> (w - j * d)) != (bv >> (w - j * d)))) begin
                    k = j;
                    found = 1;
                end
            end
        end
    endfunction

    // Present a start for one edge, then scramble the inputs.
    task automatic kick(input bit sel4, input logic [15:0] av, input logic [15:0] bv,
                        input bit ei, input bit gi);
        if (sel4) begin
            a4 = av[3:0]; b4 = bv[3:0]; eq4 = ei; gt4 = gi; start4 = 1'b1;
        end else begin
            a16 = av; b16 = bv; eq16 = ei; gt16 = gi; start16 = 1'b1;
        end
        @(posedge clk); #1;
        start4 = 1'b0; start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom);
        eq16 = 1'($urandom); gt16 = 1'($urandom);
        a4 = 4'($urandom); b4 = 4'($urandom);
        eq4 = 1'($urandom); gt4 = 1'($urandom);
    endtask

    // Bounded wait for done; k = -1 on timeout. busy_ok drops if busy was
    // ever low on a cycle before done.
    task automatic wait_done(input bit sel4, input int budget, output int k, output bit busy_ok);
        logic [4:0] o;
        k = -1;
        busy_ok = 1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            o = outs(sel4);
            if (o[3]) begin
                k = c;
                break;
            end
            if (!o[4]) busy_ok = 0;
        end
    endtask

    task automatic run(input bit sel4, input logic [15:0] av, input logic [15:0] bv,
                       input bit ei, input bit gi, input string tag);
        int w, ek, k;
        bit bok;
        logic [2:0] eoh;
        logic [4:0] o;
        w = sel4 ? 4 : 16;
        model(w, 2, int'(sel4 ? {12'd0, av[3:0]} : av), int'(sel4 ? {12'd0, bv[3:0]} : bv),
              ei, gi, eoh, ek);
        kick(sel4, av, bv, ei, gi);
        o = outs(sel4);
        check({tag, " busy/done after start"}, 32'(o[4:3]), 32'(2'b10));
        check({tag, " cleared at start"}, 32'(o[2:0]), 32'(3'b000));
        wait_done(sel4, w / 2 + 2, k, bok);
        o = outs(sel4);
        check({tag, " latency"}, k, ek);
        check({tag, " result"}, 32'(o[2:0]), 32'(eoh));
        check({tag, " busy while comparing"}, 32'(bok), 32'(1));
        check({tag, " busy at done"}, 32'(o[4]), 32'(0));
        @(posedge clk); #1;
        o = outs(sel4);
        check({tag, " done fall/hold"}, 32'(o), 32'({2'b00, eoh}));
    endtask

    initial begin
        int k;
        bit bok;
        logic [4:0] o;
        int dones, busies;
        logic [15:0] av, bv;
        bit ei, gi;
        int mode;

        vectors = 0;
        miscompares = 0;

        // 1. reset with start held high
        rst_n = 1'b0;
        start16 = 1'b1; start4 = 1'b1;
        a16 = 16'h1234; b16 = 16'h1234; eq16 = 1'b1; gt16 = 1'b0;
        a4 = 4'h3; b4 = 4'h3; eq4 = 1'b1; gt4 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("reset outs16", 32'(outs(0)), 32'(0));
        check("reset outs4", 32'(outs(1)), 32'(0));
        start16 = 1'b0; start4 = 1'b0;
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post-reset idle16", 32'(outs(0)), 32'(0));
        check("post-reset idle4", 32'(outs(1)), 32'(0));

        // 2. equal operands, full-length compare
        run(0, 16'h1234, 16'h1234, 1, 0, "eq1234");

        // 3. early gt, then start on the done cycle, late lt, and hold
        kick(0, 16'h8000, 16'h7FFF, 1, 0);
        wait_done(0, 10, k, bok);
        o = outs(0);
        check("8000>7FFF latency", k, 1);
        check("8000>7FFF result", 32'(o[2:0]), 32'(3'b010));
        kick(0, 16'h0001, 16'h0002, 1, 0);
        o = outs(0);
        check("start on done: done fell, busy", 32'(o), 32'(5'b10000));
        wait_done(0, 10, k, bok);
        o = outs(0);
        check("0001<0002 latency", k, 8);
        check("0001<0002 result", 32'(o[2:0]), 32'(3'b001));
        repeat (4) @(posedge clk);
        #1;
        check("lt hold", 32'(outs(0)), 32'(5'b00001));

        // 4. cascade precedence
        run(0, 16'h0000, 16'hFFFF, 0, 1, "cascade gt");
        run(0, 16'hFFFF, 16'h0000, 0, 0, "cascade lt");
        run(0, 16'h5A5A, 16'h5A5A, 1, 1, "cascade eq_in wins");

        // 5a. start while busy is ignored
        kick(0, 16'h1234, 16'h1234, 1, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        a16 = 16'h0000; b16 = 16'hFFFF; eq16 = 1'b0; gt16 = 1'b1; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        check("busy start ignored", 32'(outs(0)), 32'(5'b10000));
        wait_done(0, 10, k, bok);
        check("busy start latency", 3 + k, 8);
        check("busy start result", 32'(outs(0)), 32'(5'b01100));

        // 5b. reset mid-comparison
        @(posedge clk); #1;
        kick(0, 16'h1234, 16'h1234, 1, 0);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid reset outs", 32'(outs(0)), 32'(0));
        @(posedge clk); #3;
        rst_n = 1'b1;
        dones = 0; busies = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            o = outs(0);
            if (o[3]) dones++;
            if (o[4]) busies++;
        end
        check("mid reset no done", dones, 0);
        check("mid reset no busy", busies, 0);

        // randomized 16-bit compares
        for (int i = 0; i < 150; i++) begin
            av = 16'($urandom);
            mode = $urandom_range(0, 3);
            ei = 1'b1;
            gi = 1'($urandom);
            case (mode)
                0: bv = 16'($urandom);
                1: bv = av;
                2: bv = av ^ (16'($urandom_range(1, 3)) << (2 * $urandom_range(0, 7)));
                default: begin bv = 16'($urandom); ei = 1'($urandom); end
            endcase
            run(0, av, bv, ei, gi, $sformatf("rand%0d a=%h b=%h e=%0d g=%0d", i, av, bv, ei, gi));
        end

        // 6. exhaustive sweep on the 4-bit instance
        for (int e = 0; e < 2; e++) begin
            for (int g = 0; g < 2; g++) begin
                for (int x = 0; x < 16; x++) begin
                    for (int y = 0; y < 16; y++) begin
                        run(1, 16'(x), 16'(y), e[0], g[0],
                            $sformatf("sweep e%0d g%0d a%0d b%0d", e, g, x, y));
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
